// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto a configuration chain and returns the bits it shifts out as readback words.
// Each shift captures ccff_tail; readback backpressure stalls shifting once the capture and holding registers are both full.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 4,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [CNT_W-1:0]  bit_count,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] FULL = CW'(WORD_W);

  if (CHAIN_LEN < 1) begin : g_chain_len_chk
    $error("CHAIN_LEN must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [WORD_W-1:0] wreg, cap, hold;
  logic [CW-1:0]     wcnt, ccnt;
  logic              hold_vld;
  logic              rb_fire, hold_free, xfer, shift, accept;
  logic [WORD_W-1:0] xfer_dat;

  always_ff @(posedge prog_clk) begin
    if (pReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rb_fire   = hold_vld & rb_ready;
    hold_free = !hold_vld || rb_ready;
    xfer      = 1'b0;
    // A partial capture is left-justified; a full one shifts by zero.
    xfer_dat  = cap << (FULL - ccnt);
    if (state == RUN)        xfer = (ccnt == FULL) && hold_free;
    else if (state == FLUSH) xfer = (ccnt != '0) && hold_free;
    shift     = (state == RUN) && (wcnt != '0) && (remaining != '0) && ((ccnt != FULL) || xfer);
    s_ready   = (state == RUN) && ((wcnt == '0) || ((wcnt == CW'(1)) && shift))
                && ((remaining - CNT_W'(shift)) != '0);
    accept    = s_valid && s_ready;
    shift_en  = shift;
    ccff_head = (state == RUN) ? wreg[WORD_W-1] : 1'b0;
    busy      = (state == RUN) || (state == FLUSH);
    done      = (state == DONE);
    case (state)
      IDLE:  if (start) state_nxt = (bit_count == '0) ? DONE : RUN;
      RUN:   if (shift && (remaining == CNT_W'(1))) state_nxt = FLUSH;
      FLUSH: if ((ccnt == '0) && (!hold_vld || rb_fire)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      remaining <= '0;
      wreg      <= '0;
      wcnt      <= '0;
      cap       <= '0;
      ccnt      <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        remaining <= bit_count;
        wcnt      <= '0;
        cap       <= '0;
        ccnt      <= '0;
      end else begin
        if (shift) remaining <= remaining - CNT_W'(1);
        // Acceptance with a shift only happens on the last pending bit, so the new word overwrites it.
        if (accept) begin
          wreg <= s_data;
          wcnt <= FULL;
        end else if (shift) begin
          wreg <= wreg << 1;
          wcnt <= wcnt - CW'(1);
        end
        if (shift) begin
          if (xfer) begin
            cap  <= {{(WORD_W-1){1'b0}}, ccff_tail};
            ccnt <= CW'(1);
          end else begin
            cap  <= {cap[WORD_W-2:0], ccff_tail};
            ccnt <= ccnt + CW'(1);
          end
        end else if (xfer) begin
          cap  <= '0;
          ccnt <= '0;
        end
      end
      if (xfer) begin
        hold     <= xfer_dat;
        hold_vld <= 1'b1;
      end else if (rb_fire) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign rb_data  = hold;
  assign rb_valid = hold_vld;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a chain model drives ccff_tail, expectations come from a bit-sequence model.
module tb_ccff_bitstream_loader;
  localparam int W  = 8;
  localparam int CL = 4;
  localparam int CN = 16;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1, start = 1'b0, s_valid = 1'b0, rb_ready = 1'b0;
  logic [CN-1:0] bit_count = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, ccff_head, shift_en, ccff_tail, rb_valid, busy, done;
  logic [W-1:0]  rb_data;
  logic [CL-1:0] chain = '1;

  assign ccff_tail = chain[CL-1];
  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(W), .CNT_W(CN)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .bit_count(bit_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .busy(busy), .done(done)
  );

  int n_checks = 0, n_fail = 0;
  logic [W-1:0] src_q[$], rb_q[$], load_words[$];
  logic hd_q[$];
  int vmode = 0, rmode = 0, cyc = 0, nshift = 0, nacc = 0, nbits_cur = 0, pend_viol = 0;
  int first_sh = -1, last_sh = -1, last_hs = -1, done_cyc = -1;
  logic sh_pend = 1'b0, head_pend = 1'b0, rst_drive = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: apply the previous shift to the chain model, drive inputs, sample outputs.
  task automatic cycle();
    @(negedge prog_clk);
    if (sh_pend) chain = {chain[CL-2:0], head_pend};
    sh_pend = 1'b0;
    pReset  = rst_drive;
    start   = 1'b0;
    cyc++;
    case (vmode)
      0:       s_valid = (src_q.size() > 0);
      1:       s_valid = (cyc % 2 == 0) && (src_q.size() > 0);
      default: s_valid = ($urandom_range(0, 2) != 0) && (src_q.size() > 0);
    endcase
    s_data = (src_q.size() > 0) ? src_q[0] : W'($urandom);
    case (rmode)
      0:       rb_ready = 1'b1;
      1:       rb_ready = 1'b0;
      default: rb_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (shift_en) begin
      if (nshift >= ((nacc * W < nbits_cur) ? nacc * W : nbits_cur)) pend_viol++;
      hd_q.push_back(ccff_head);
      sh_pend   = 1'b1;
      head_pend = ccff_head;
      if (nshift == 0) first_sh = cyc;
      last_sh = cyc;
      nshift++;
    end
    if (s_valid && s_ready) begin
      void'(src_q.pop_front());
      nacc++;
    end
    if (rb_valid && rb_ready) begin
      rb_q.push_back(rb_data);
      last_hs = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic kick(input int nbits, input logic [CL-1:0] preset);
    chain = preset;
    hd_q.delete();
    rb_q.delete();
    nshift = 0; nacc = 0; pend_viol = 0; nbits_cur = nbits;
    first_sh = -1; last_sh = -1; last_hs = -1; done_cyc = -1;
    @(negedge prog_clk);
    sh_pend   = 1'b0;
    start     = 1'b1;
    bit_count = CN'(nbits);
    s_valid   = 1'b0;
    rb_ready  = 1'b1;
    cyc       = 0;
  endtask

  task automatic do_load(input string nm, input int nbits, input logic [CL-1:0] preset,
                         input int vm, input int rm, input int bp);
    bit seq[$];
    int nw;
    logic [W-1:0] tmp, ew;
    logic [CL-1:0] ech;
    nw = (nbits + W - 1) / W;
    src_q.delete();
    for (int i = 0; i < nw; i++) src_q.push_back(load_words[i]);
    src_q.push_back(W'($urandom));
    vmode = vm;
    rmode = (bp > 0) ? 1 : rm;
    kick(nbits, preset);
    cycle();
    chk({nm, " busy_c1"}, busy, 1);
    chk({nm, " s_ready_c1"}, s_ready, 1);
    if (bp > 0) begin
      repeat (bp - 1) cycle();
      chk({nm, " bp_shifts"}, nshift, 2 * W);
      repeat (20) cycle();
      chk({nm, " bp_stalled"}, nshift, 2 * W);
      rmode = rm;
    end
    while (done_cyc < 0 && cyc < 3000) cycle();
    chk({nm, " done_seen"}, done_cyc >= 0, 1);
    cycle();
    chk({nm, " idle_after"}, {busy, done}, 0);

    // Bits leaving the tail: the old chain contents, then the stream itself.
    for (int i = CL - 1; i >= 0; i--) seq.push_back(preset[i]);
    for (int k = 0; k < nbits; k++) begin
      tmp = load_words[k / W];
      seq.push_back(tmp[W - 1 - k % W]);
    end
    chk({nm, " nshift"}, nshift, nbits);
    for (int k = 0; k < nbits && k < hd_q.size(); k++) chk({nm, " head"}, hd_q[k], seq[k + CL]);
    chk({nm, " words_fetched"}, nacc, nw);
    chk({nm, " rb_count"}, rb_q.size(), nw);
    for (int w = 0; w < nw && w < rb_q.size(); w++) begin
      ew = '0;
      for (int j = 0; j < W; j++) if (w * W + j < nbits) ew[W - 1 - j] = seq[w * W + j];
      chk({nm, " rb_word"}, rb_q[w], ew);
    end
    for (int i = 0; i < CL; i++) ech[CL - 1 - i] = seq[nbits + i];
    chk({nm, " final_chain"}, chain, ech);
    chk({nm, " done_after_hs"}, done_cyc, last_hs + 1);
    chk({nm, " shift_without_bit"}, pend_viol, 0);
    if (vm == 0 && rm == 0 && bp == 0) begin
      chk({nm, " first_shift_cyc"}, first_sh, 2);
      chk({nm, " no_bubbles"}, last_sh - first_sh + 1, nbits);
    end
  endtask

  initial begin
    // Reset with random inputs, including start.
    for (int i = 0; i < 2; i++) begin
      @(negedge prog_clk);
      pReset = 1'b1; start = 1'($urandom); bit_count = CN'($urandom_range(1, 100));
      s_valid = 1'($urandom); s_data = W'($urandom); rb_ready = 1'($urandom);
      #1;
      chk("rst_outs", {s_ready, shift_en, ccff_head, rb_valid, busy, done}, 0);
      chk("rst_rb_data", rb_data, 0);
    end
    @(negedge prog_clk);
    pReset = 1'b0; start = 1'b0; s_valid = 1'b0;
    #1;
    chk("rst_start_ignored", busy, 0);
    @(negedge prog_clk);
    #1;
    chk("rst_still_idle", {busy, done, s_ready}, 0);

    load_words = '{8'hA5};
    do_load("single", 8, 4'hF, 0, 0, 0);
    chk("single_rb_FA", rb_q.size() > 0 ? rb_q[0] : 8'h00, 8'hFA);
    chk("single_chain_0101", chain, 4'b0101);

    load_words = '{8'hA5, 8'h3C};
    do_load("partial", 12, 4'hF, 0, 0, 0);
    chk("partial_rb_50", rb_q.size() > 1 ? rb_q[1] : 8'h00, 8'h50);

    load_words = '{W'($urandom), W'($urandom), W'($urandom)};
    do_load("backpressure", 24, CL'($urandom), 0, 0, 40);

    load_words = '{W'($urandom), W'($urandom), W'($urandom)};
    do_load("gaps", 20, CL'($urandom), 1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      int nb;
      nb = $urandom_range(1, 40);
      load_words.delete();
      for (int i = 0; i < 6; i++) load_words.push_back(W'($urandom));
      do_load("rand", nb, CL'($urandom), 2, 2, 0);
    end

    // Zero-length load.
    src_q.delete();
    vmode = 0; rmode = 0;
    kick(0, 4'hF);
    cycle();
    chk("zero_done_c1", done, 1);
    chk("zero_quiet_c1", {shift_en, rb_valid, busy}, 0);
    cycle();
    chk("zero_done_pulse", {done, busy, shift_en}, 0);

    // Reset in the middle of a load, then a clean reload.
    src_q.delete();
    src_q.push_back(8'hA5);
    vmode = 0; rmode = 0;
    kick(8, 4'hF);
    while (nshift < 4 && cyc < 50) cycle();
    rst_drive = 1'b1;
    cycle();
    rst_drive = 1'b0;
    cycle();
    chk("midrst_outs", {s_ready, shift_en, ccff_head, rb_valid, busy, done}, 0);
    chk("midrst_rb_data", rb_data, 0);
    load_words = '{8'hA5};
    do_load("after_rst", 8, 4'hF, 0, 0, 0);
    chk("after_rst_rb_FA", rb_q.size() > 0 ? rb_q[0] : 8'h00, 8'hFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
